// File: rtl/tx_packet_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tx_packet_scheduler
// Brief    : Round-robin sequencer sharing one SYNC/bit-stuff/NRZI Transmitter
// Revision : 1.0 - initial release
// ============================================================================
module tx_packet_scheduler #(
    parameter int NUM_REQ     = 3,
    parameter int SYNC_CYCLES = 8,
    parameter int WORD_CYCLES = 20,
    parameter int IFG_CYCLES  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [4*NUM_REQ-1:0]  req_len,
    input  logic [16*NUM_REQ-1:0] req_data,
    input  logic                  stuff_en,
    input  logic [7:0]            sync_cfg,
    output logic [NUM_REQ-1:0]    grant,
    output logic [NUM_REQ-1:0]    word_take,
    output logic                  pkt_done,
    output logic                  pkt_abort,
    output logic                  busy,
    output logic                  SIE,
    output logic                  STUFF_OPER_tx,
    output logic [7:0]            sync_data,
    output logic [15:0]           data_in
);
    localparam int c_IDX_W   = $clog2(NUM_REQ);
    localparam int c_CNT_MAX = (SYNC_CYCLES > WORD_CYCLES)
                             ? ((SYNC_CYCLES > IFG_CYCLES) ? SYNC_CYCLES : IFG_CYCLES)
                             : ((WORD_CYCLES > IFG_CYCLES) ? WORD_CYCLES : IFG_CYCLES);
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_SYNC_LAST = c_CNT_W'(SYNC_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_WORD_LAST = c_CNT_W'(WORD_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_IFG_LAST  = c_CNT_W'(IFG_CYCLES - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST  = c_IDX_W'(NUM_REQ - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_SYNC = 2'd1;
    localparam logic [1:0] c_ST_DATA = 2'd2;
    localparam logic [1:0] c_ST_GAP  = 2'd3;

    logic [1:0]         r_state,  w_state;
    logic [c_CNT_W-1:0] r_cnt,    w_cnt;
    logic [3:0]         r_word,   w_word;
    logic [3:0]         r_len,    w_len;
    logic [c_IDX_W-1:0] r_winner, w_winner;
    logic [c_IDX_W-1:0] r_ptr,    w_ptr;
    logic [NUM_REQ-1:0] r_grant,  w_grant;
    logic [NUM_REQ-1:0] r_take,   w_take;
    logic               r_done,   w_done;
    logic               r_abort,  w_abort;
    logic               r_busy,   w_busy;
    logic               r_sie,    w_sie;
    logic               r_stuff,  w_stuff;
    logic [7:0]         r_sync,   w_sync;
    logic [15:0]        r_data,   w_data;

    logic               w_found;
    logic [c_IDX_W-1:0] w_arb_idx;
    logic [3:0]         w_arb_len;
    logic [3:0]         w_len_eff;
    logic [NUM_REQ-1:0] w_arb_onehot;
    logic [15:0]        w_cur_data;
    logic               w_win_req;
    logic               w_enter_gap;

    // First requester at or after the pointer, wrapping modulo NUM_REQ
    always_comb begin
        w_found   = 1'b0;
        w_arb_idx = '0;
        for (int o = 0; o < NUM_REQ; o++) begin
            if (!w_found && req[(int'(r_ptr) + o) % NUM_REQ]) begin
                w_found   = 1'b1;
                w_arb_idx = c_IDX_W'((int'(r_ptr) + o) % NUM_REQ);
            end
        end
    end

    assign w_arb_len    = req_len[4*w_arb_idx +: 4];
    assign w_len_eff    = (w_arb_len == 4'd0) ? 4'd1 : w_arb_len;
    assign w_arb_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_arb_idx;
    assign w_cur_data   = req_data[16*r_winner +: 16];
    assign w_win_req    = req[r_winner];

    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_word      = r_word;
        w_len       = r_len;
        w_winner    = r_winner;
        w_ptr       = r_ptr;
        w_grant     = r_grant;
        w_take      = '0;
        w_done      = 1'b0;
        w_abort     = 1'b0;
        w_sie       = r_sie;
        w_stuff     = r_stuff;
        w_sync      = r_sync;
        w_data      = r_data;
        w_enter_gap = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_found) begin
                    w_state  = c_ST_SYNC;
                    w_cnt    = '0;
                    w_len    = w_len_eff;
                    w_winner = w_arb_idx;
                    w_ptr    = (w_arb_idx == c_IDX_LAST) ? '0 : w_arb_idx + 1'b1;
                    w_grant  = w_arb_onehot;
                    w_sie    = 1'b1;
                    w_stuff  = stuff_en;
                    w_sync   = sync_cfg;
                    w_data   = '0;
                end
            end
            c_ST_SYNC: begin
                if (!w_win_req) begin
                    w_enter_gap = 1'b1;
                    w_abort     = 1'b1;
                end else if (r_cnt == c_SYNC_LAST) begin
                    w_state = c_ST_DATA;
                    w_cnt   = '0;
                    w_word  = 4'd1;
                    w_data  = w_cur_data;
                    w_take  = r_grant;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            c_ST_DATA: begin
                // A dropped request wins over a slot boundary: no capture on abort
                if (!w_win_req) begin
                    w_enter_gap = 1'b1;
                    w_abort     = 1'b1;
                end else if (r_cnt == c_WORD_LAST) begin
                    if (r_word == r_len) begin
                        w_enter_gap = 1'b1;
                        w_done      = 1'b1;
                    end else begin
                        w_cnt  = '0;
                        w_word = r_word + 4'd1;
                        w_data = w_cur_data;
                        w_take = r_grant;
                    end
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            c_ST_GAP: begin
                if (r_cnt == c_IFG_LAST) begin
                    w_state = c_ST_IDLE;
                    w_cnt   = '0;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state = c_ST_IDLE;
                w_cnt   = '0;
            end
        endcase
        if (w_enter_gap) begin
            w_state = c_ST_GAP;
            w_cnt   = '0;
            w_grant = '0;
            w_sie   = 1'b0;
            w_stuff = 1'b0;
            w_sync  = '0;
            w_data  = '0;
        end
        w_busy = (w_state != c_ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= c_ST_IDLE;
            r_cnt    <= '0;
            r_word   <= '0;
            r_len    <= '0;
            r_winner <= '0;
            r_ptr    <= '0;
            r_grant  <= '0;
            r_take   <= '0;
            r_done   <= 1'b0;
            r_abort  <= 1'b0;
            r_busy   <= 1'b0;
            r_sie    <= 1'b0;
            r_stuff  <= 1'b0;
            r_sync   <= '0;
            r_data   <= '0;
        end else begin
            r_state  <= w_state;
            r_cnt    <= w_cnt;
            r_word   <= w_word;
            r_len    <= w_len;
            r_winner <= w_winner;
            r_ptr    <= w_ptr;
            r_grant  <= w_grant;
            r_take   <= w_take;
            r_done   <= w_done;
            r_abort  <= w_abort;
            r_busy   <= w_busy;
            r_sie    <= w_sie;
            r_stuff  <= w_stuff;
            r_sync   <= w_sync;
            r_data   <= w_data;
        end
    end

    assign grant         = r_grant;
    assign word_take     = r_take;
    assign pkt_done      = r_done;
    assign pkt_abort     = r_abort;
    assign busy          = r_busy;
    assign SIE           = r_sie;
    assign STUFF_OPER_tx = r_stuff;
    assign sync_data     = r_sync;
    assign data_in       = r_data;

endmodule
`default_nettype wire

// File: tb/tb_tx_packet_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_packet_scheduler
// Brief    : Directed + randomized bench with a packet-timeline reference model
// Revision : 1.0 - initial release
// ============================================================================
module tb_tx_packet_scheduler;
    localparam int N  = 3;
    localparam int SC = 8;
    localparam int WC = 20;
    localparam int IC = 4;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req;
    logic [4*N-1:0]  req_len;
    logic [16*N-1:0] req_data;
    logic            stuff_en;
    logic [7:0]      sync_cfg;
    logic [N-1:0]    grant;
    logic [N-1:0]    word_take;
    logic            pkt_done;
    logic            pkt_abort;
    logic            busy;
    logic            SIE;
    logic            STUFF_OPER_tx;
    logic [7:0]      sync_data;
    logic [15:0]     data_in;

    tx_packet_scheduler #(
        .NUM_REQ(N), .SYNC_CYCLES(SC), .WORD_CYCLES(WC), .IFG_CYCLES(IC)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_len(req_len), .req_data(req_data),
        .stuff_en(stuff_en), .sync_cfg(sync_cfg), .grant(grant), .word_take(word_take),
        .pkt_done(pkt_done), .pkt_abort(pkt_abort), .busy(busy), .SIE(SIE),
        .STUFF_OPER_tx(STUFF_OPER_tx), .sync_data(sync_data), .data_in(data_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: one packet described by its grant edge and gap edge
    int           cyc = 0;
    bit           m_act = 0;
    int           m_g, m_G, m_len, m_win;
    int           m_ptr = 0;
    bit           m_abort, m_stuff;
    logic [7:0]   m_sync;
    logic [15:0]  m_word;
    logic [N-1:0] m_take;

    // Requester side and observation counters
    bit           auto_rel = 1;
    logic [15:0]  wq [N][$];
    int           c_sie, c_stuff, c_done, c_abort, c_bcf2, c_1234;
    int           c_take [N];
    logic [N-1:0] prev_grant = '0;
    int           rise_cyc [$];
    logic [N-1:0] rise_val [$];
    logic [N-1:0] exp_rr [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    int           t0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_edge();
        int k;
        bit found;
        cyc++;
        m_take = '0;
        if (rst == 1'b0) begin
            m_act = 0;
            m_ptr = 0;
            return;
        end
        if (m_act) begin
            k = cyc - m_g;
            if (m_G < 0) begin
                if (req[m_win] == 1'b0) begin
                    m_G = cyc; m_abort = 1;
                end else if (k == SC + WC * m_len) begin
                    m_G = cyc; m_abort = 0;
                end else if (k >= SC && (k - SC) % WC == 0) begin
                    m_word = req_data[16*m_win +: 16];
                    m_take[m_win] = 1'b1;
                end
            end else if (cyc == m_G + IC) begin
                m_act = 0;
            end
        end else if (req != '0) begin
            found = 0;
            for (int o = 0; o < N; o++) begin
                if (!found && req[(m_ptr + o) % N]) begin
                    found = 1;
                    m_win = (m_ptr + o) % N;
                end
            end
            m_ptr   = (m_win + 1) % N;
            m_act   = 1;
            m_g     = cyc;
            m_G     = -1;
            m_len   = (req_len[4*m_win +: 4] == 4'd0) ? 1 : int'(req_len[4*m_win +: 4]);
            m_stuff = stuff_en;
            m_sync  = sync_cfg;
            m_word  = '0;
        end
    endtask

    task automatic check_outputs();
        logic [N-1:0] eg, et;
        logic ed, ea, eb, es, est;
        logic [7:0] esy;
        logic [15:0] edat;
        bit chk_sync;
        int k;
        eg = '0; et = '0; ed = 0; ea = 0; eb = 0; es = 0; est = 0;
        esy = '0; edat = '0; chk_sync = 1;
        if (m_act) begin
            eb = 1;
            k  = cyc - m_g;
            if (m_G < 0) begin
                eg  = N'(1) << m_win;
                es  = 1;
                est = m_stuff;
                et  = m_take;
                if (k < SC) esy = m_sync;
                else begin
                    chk_sync = 0;
                    edat = m_word;
                end
            end else begin
                ed = (cyc == m_G) && !m_abort;
                ea = (cyc == m_G) && m_abort;
            end
        end
        chk("grant", grant, eg);
        chk("word_take", word_take, et);
        chk("pkt_done", pkt_done, ed);
        chk("pkt_abort", pkt_abort, ea);
        chk("busy", busy, eb);
        chk("SIE", SIE, es);
        chk("STUFF_OPER_tx", STUFF_OPER_tx, est);
        chk("data_in", data_in, edat);
        if (chk_sync) chk("sync_data", sync_data, esy);
    endtask

    task automatic clr();
        c_sie = 0; c_stuff = 0; c_done = 0; c_abort = 0; c_bcf2 = 0; c_1234 = 0;
        for (int i = 0; i < N; i++) c_take[i] = 0;
        rise_cyc.delete();
        rise_val.delete();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        check_outputs();
        c_sie   += int'(SIE);
        c_stuff += int'(STUFF_OPER_tx);
        c_done  += int'(pkt_done);
        c_abort += int'(pkt_abort);
        c_bcf2  += int'(data_in == 16'hBCF2);
        c_1234  += int'(data_in == 16'h1234);
        for (int i = 0; i < N; i++) c_take[i] += int'(word_take[i]);
        if (grant != '0 && prev_grant == '0) begin
            rise_cyc.push_back(cyc);
            rise_val.push_back(grant);
        end
        prev_grant = grant;
        // Requester advances its word once the model says it was captured
        for (int i = 0; i < N; i++) begin
            if (m_take[i]) begin
                if (wq[i].size() > 0) req_data[16*i +: 16] = wq[i].pop_front();
                else req_data[16*i +: 16] = 16'($urandom);
            end
        end
        if (auto_rel && m_act && m_G == cyc) req[m_win] = 1'b0;
    endtask

    initial begin
        rst = 1'b0; req = '1; req_len = '0; req_data = '0; stuff_en = 1'b0; sync_cfg = '0;
        clr();

        // 1: reset with all requests high
        repeat (3) step();
        chk("rst_grant", grant, 0);
        chk("rst_SIE", SIE, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data_in", data_in, 0);
        rst = 1'b1; req = '0;
        step();

        // 2: single two-word packet from requester 0
        clr();
        req_len[3:0] = 4'd2; sync_cfg = 8'h7E; stuff_en = 1'b1;
        req_data[15:0] = 16'hBCF2;
        wq[0].push_back(16'h1234);
        req[0] = 1'b1;
        t0 = cyc;
        repeat (60) step();
        stuff_en = 1'b0;
        chk("single_grant_latency", (rise_cyc.size() > 0) ? rise_cyc[0] - t0 : -1, 1);
        chk("single_sie_cycles", c_sie, SC + 2 * WC);
        chk("single_stuff_cycles", c_stuff, SC + 2 * WC);
        chk("single_takes", c_take[0], 2);
        chk("single_done", c_done, 1);
        chk("single_word0_cycles", c_bcf2, WC);
        chk("single_word1_cycles", c_1234, WC);

        // 3: round-robin with all requests held, after a reset to clear the pointer
        rst = 1'b0; step(); rst = 1'b1;
        clr();
        auto_rel = 0;
        req_len = 12'h111;
        req = 3'b111;
        repeat (100) step();
        chk("rr_count", rise_val.size(), 4);
        if (rise_val.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("rr_grant", rise_val[i], exp_rr[i]);
                if (i > 0) chk("rr_spacing", rise_cyc[i] - rise_cyc[i-1], 1 + SC + WC + IC);
            end
        end
        req = 3'b001;
        auto_rel = 1;
        repeat (40) step();

        // 4: abort in the 5th cycle of word 2
        clr();
        req_len[7:4] = 4'd3;
        req[1] = 1'b1;
        for (int i = 0; i < 80; i++) begin
            step();
            if (m_act && m_G < 0 && m_win == 1 && cyc - m_g == SC + WC + 4) req[1] = 1'b0;
        end
        chk("abort_takes", c_take[1], 2);
        chk("abort_pulses", c_abort, 1);
        chk("abort_done", c_done, 0);

        // 5: zero length treated as one word
        clr();
        req_len[11:8] = 4'd0;
        req[2] = 1'b1;
        repeat (40) step();
        chk("zero_takes", c_take[2], 1);
        chk("zero_done", c_done, 1);
        chk("zero_sie_cycles", c_sie, SC + WC);

        // 6: reset during SYNC, then requester 2 is granted
        clr();
        req_len[3:0] = 4'd1;
        req[0] = 1'b1;
        repeat (3) step();
        rst = 1'b0; req = 3'b100; req_len[11:8] = 4'd1;
        step();
        chk("mid_rst_grant", grant, 0);
        chk("mid_rst_SIE", SIE, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_data_in", data_in, 0);
        chk("mid_rst_sync", sync_data, 0);
        chk("mid_rst_stuff", STUFF_OPER_tx, 0);
        rst = 1'b1;
        step();
        chk("post_rst_grant", grant, 3'b100);
        repeat (40) step();
        chk("post_rst_done", c_done, 1);
        chk("post_rst_abort", c_abort, 0);

        // Randomized traffic, aborts and resets against the model
        for (int n = 0; n < 3000; n++) begin
            stuff_en = 1'($urandom);
            sync_cfg = 8'($urandom);
            rst = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
            for (int i = 0; i < N; i++) begin
                if (!req[i]) begin
                    if ($urandom_range(0, 15) == 0) begin
                        req_len[4*i +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                                                       : 4'($urandom_range(0, 2));
                        req[i] = 1'b1;
                    end
                end else if (m_act && m_win == i && m_G < 0 && $urandom_range(0, 299) == 0) begin
                    req[i] = 1'b0;
                end
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
